// File: rtl/alu4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu4_pkg
//  Description : Shared opcode constants, nibble-order helper and sequencer
//                state type for the 4-bit ALU and its multi-cycle controller.
//  Revision    : 1.0  initial release
// ============================================================================
package alu4_pkg;

    // Opcodes used by the controller's ordering rule and by integration code
    localparam logic [3:0] OP_ADC = 4'h4;   // A + B + cin
    localparam logic [3:0] OP_RRC = 4'hF;   // rotate right through rcin
    localparam logic [3:0] OP_SHR = 4'hD;   // shift right

    // Sequencer states; the controller keeps these as plain 2-bit codes
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

    // Right shifts/rotates must see the high nibble first so the bit shifted
    // out of each nibble can feed the next lower one through rcout/rcin.
    function automatic logic op_is_msb_first(input logic [3:0] op);
        return ((op[3:2] == 2'b11) && op[0]) || (op == 4'b0111);
    endfunction

endpackage : alu4_pkg
`default_nettype wire

// File: rtl/alu4_nibble_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu4_nibble_sequencer
//  Description : Runs an external combinational 4-bit ALU over NIBBLES-wide
//                operands, one nibble per clock, chaining math and rotate
//                carries and accumulating result and flags. start/busy/done
//                handshake; back-to-back ops via the DONE state.
//  Revision    : 1.0  initial release
// ============================================================================
module alu4_nibble_sequencer
    import alu4_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // request side
    input  logic                   start,
    input  logic [3:0]             op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    input  logic                   rcin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   rcout,
    output logic                   ovf,
    output logic                   zero,
    // ALU core side
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_op,
    output logic                   alu_cin,
    output logic                   alu_rcin,
    input  logic [3:0]             alu_y,
    input  logic                   alu_cout,
    input  logic                   alu_rcout,
    input  logic                   alu_ovf
);

    localparam int c_width = 4 * NIBBLES;
    localparam int c_cnt_w = $clog2(NIBBLES);

    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NIBBLES - 1);

    localparam logic [1:0] c_st_idle = SEQ_IDLE;
    localparam logic [1:0] c_st_run  = SEQ_RUN;
    localparam logic [1:0] c_st_done = SEQ_DONE;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [3:0]           r_op;
    logic [c_width-1:0]   r_a;
    logic [c_width-1:0]   r_b;
    logic [c_width-1:0]   r_result;
    logic                 r_carry;
    logic                 r_rcarry;
    logic                 r_cout;
    logic                 r_rcout;
    logic                 r_ovf;
    logic                 r_zero;

    logic                 w_accept;
    logic                 w_run;
    logic                 w_last;
    logic                 w_msb_first;
    logic [c_cnt_w-1:0]   w_idx;
    logic [c_cnt_w+1:0]   w_base;

    // A request is taken whenever no nibbles are in flight (IDLE or DONE)
    assign w_accept    = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_run       = (r_state == c_st_run);
    assign w_last      = (r_cnt == c_last);
    assign w_msb_first = op_is_msb_first(r_op);

    // Nibble position for this cycle and its bit offset in the wide words
    assign w_idx  = w_msb_first ? (c_last - r_cnt) : r_cnt;
    assign w_base = {w_idx, 2'b00};

    // Next-state selection for the IDLE/RUN/DONE controller
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_next = c_st_run;
            c_st_run:  if (w_last) w_state_next = c_st_done;
            c_st_done: w_state_next = start ? c_st_run : c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // State register; reset aborts any op in flight without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request latch and nibble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= '0;
        end else if (w_run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Carry chain: seeded from the request, then fed back from the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry  <= 1'b0;
            r_rcarry <= 1'b0;
        end else if (w_accept) begin
            r_carry  <= cin;
            r_rcarry <= rcin;
        end else if (w_run) begin
            r_carry  <= alu_cout;
            r_rcarry <= alu_rcout;
        end
    end

    // Result and flag accumulation; values persist until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_rcout  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_zero   <= 1'b1;
        end else if (w_run) begin
            r_result[w_base +: 4] <= alu_y;
            r_zero   <= r_zero & (alu_y == 4'h0);
            r_cout   <= alu_cout;
            r_rcout  <= alu_rcout;
            r_ovf    <= alu_ovf;
        end
    end

    // ALU drive is gated so the shared core sees zeros outside RUN
    assign alu_a    = w_run ? r_a[w_base +: 4] : 4'h0;
    assign alu_b    = w_run ? r_b[w_base +: 4] : 4'h0;
    assign alu_op   = w_run ? r_op             : 4'h0;
    assign alu_cin  = w_run ? r_carry          : 1'b0;
    assign alu_rcin = w_run ? r_rcarry         : 1'b0;

    assign busy   = w_run;
    assign done   = (r_state == c_st_done);
    assign result = r_result;
    assign cout   = r_cout;
    assign rcout  = r_rcout;
    assign ovf    = r_ovf;
    assign zero   = r_zero;

endmodule : alu4_nibble_sequencer
`default_nettype wire

// File: tb/tb_alu4_nibble_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu4_nibble_sequencer
//  Description : Self-checking bench for alu4_nibble_sequencer with a
//                behavioural ALU core and a whole-word reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu4_nibble_sequencer;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          rcin;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic          rcout;
    logic          ovf;
    logic          zero;
    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [3:0]    alu_op;
    logic          alu_cin;
    logic          alu_rcin;
    logic [3:0]    alu_y;
    logic          alu_cout;
    logic          alu_rcout;
    logic          alu_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        rc;
        logic        v;
        logic        z;
    } exp_t;

    alu4_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .rcin      (rcin),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cout      (cout),
        .rcout     (rcout),
        .ovf       (ovf),
        .zero      (zero),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_cin   (alu_cin),
        .alu_rcin  (alu_rcin),
        .alu_y     (alu_y),
        .alu_cout  (alu_cout),
        .alu_rcout (alu_rcout),
        .alu_ovf   (alu_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-bit ALU core: ADC, RRC; any other op is XOR with carries passed through
    logic [4:0] w_sum;
    always_comb begin
        w_sum     = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_cin};
        alu_y     = alu_a ^ alu_b;
        alu_cout  = alu_cin;
        alu_rcout = alu_rcin;
        alu_ovf   = 1'b0;
        case (alu_op)
            4'h4: begin
                alu_y    = w_sum[3:0];
                alu_cout = w_sum[4];
                alu_ovf  = (alu_a[3] == alu_b[3]) && (w_sum[3] != alu_a[3]);
            end
            4'hF: begin
                alu_y     = {alu_rcin, alu_a[3:1]};
                alu_rcout = alu_a[0];
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Whole-word reference: the op applied to the full 16-bit operands at once
    function automatic exp_t ref_op(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb,
                                    input logic xc, input logic xr);
        exp_t        e;
        logic [16:0] s;
        e.c  = xc;
        e.rc = xr;
        e.v  = 1'b0;
        if (o == 4'h4) begin
            s     = {1'b0, xa} + {1'b0, xb} + {16'h0, xc};
            e.res = s[15:0];
            e.c   = s[16];
            e.v   = (xa[15] == xb[15]) && (s[15] != xa[15]);
        end else if (o == 4'hF) begin
            e.res = {xr, xa[15:1]};
            e.rc  = xa[0];
        end else begin
            e.res = xa ^ xb;
        end
        e.z = (e.res == 16'h0);
        return e;
    endfunction

    function automatic logic msb_first(input logic [3:0] o);
        return (o == 4'hD) || (o == 4'hF) || (o == 4'h7);
    endfunction

    // One complete op: checks latency, result, flags and the nibble order seen by the ALU
    task automatic run_op(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb,
                          input logic xc, input logic xr, input string tag,
                          output logic [3:0] cin_seq);
        exp_t        e;
        logic [15:0] seq_a;
        logic [15:0] exp_seq;
        int          step;
        int          lat;
        e       = ref_op(o, xa, xb, xc, xr);
        seq_a   = '0;
        cin_seq = '0;
        step    = 0;
        @(negedge clk);
        op = o; a = xa; b = xb; cin = xc; rcin = xr; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        lat   = 1;
        while (!done && lat < 20) begin
            if (busy && step < 4) begin
                seq_a[step*4 +: 4] = alu_a;
                cin_seq[step]      = alu_cin;
                step++;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        exp_seq = msb_first(o) ? {xa[3:0], xa[7:4], xa[11:8], xa[15:12]} : xa;
        check({tag, " latency"}, lat, 5);
        check({tag, " result"}, result, e.res);
        check({tag, " cout"}, cout, e.c);
        check({tag, " rcout"}, rcout, e.rc);
        if (!msb_first(o)) check({tag, " ovf"}, ovf, e.v);
        check({tag, " zero"}, zero, e.z);
        check({tag, " alu_a order"}, seq_a, exp_seq);
        check({tag, " busy steps"}, step, 4);
    endtask

    logic [3:0] cseq;
    exp_t       q[$];
    exp_t       e_pop;
    logic [3:0] ops [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ops = '{4'h4, 4'hF, 4'h1, 4'hC, 4'h7};
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0; rcin = 1'b0;
        #22;
        check("reset outputs", {busy, done, cout, rcout, ovf, zero}, 6'b0);
        check("reset result", result, 16'h0);
        check("reset alu bus", {alu_a, alu_b, alu_op, alu_cin, alu_rcin}, 14'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(4'h4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "adc_wrap", cseq);
        check("adc_wrap cin chain", cseq, 4'b1110);
        run_op(4'h4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "adc_ovf", cseq);
        run_op(4'hF, 16'h1234, 16'h0000, 1'b0, 1'b1, "rrc", cseq);
        check("rrc literal", result, 16'h891A);
        run_op(4'h4, 16'h00F0, 16'h0010, 1'b1, 1'b0, "adc_mid", cseq);
        check("adc_mid cin chain", cseq, 4'b0101);
        check("adc_mid literal", result, 16'h0101);

        // start held high: accept only in IDLE/DONE, done every 5 cycles
        begin
            int last_done;
            int n_done;
            last_done = -1;
            n_done    = 0;
            q.delete();
            for (int cyc = 0; cyc < 40; cyc++) begin
                @(negedge clk);
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
                op = 4'h4; start = 1'b1;
                if (!busy) q.push_back(ref_op(4'h4, a, b, cin, rcin));
                @(posedge clk);
                #1;
                if (done) begin
                    n_done++;
                    if (last_done >= 0) check("held start done spacing", cyc - last_done, 5);
                    last_done = cyc;
                    check("held start queue nonempty", (q.size() != 0), 1);
                    if (q.size() != 0) begin
                        e_pop = q.pop_front();
                        check("held start result", result, e_pop.res);
                    end
                end
            end
            @(negedge clk);
            start = 1'b0;
            for (int cyc = 0; cyc < 10; cyc++) begin
                @(posedge clk);
                #1;
                if (done && q.size() != 0) begin
                    e_pop = q.pop_front();
                    check("held start drain result", result, e_pop.res);
                    n_done++;
                end
            end
            check("held start queue empty", q.size(), 0);
            check("held start done count", n_done, 8);
        end

        // Reset mid-RUN: everything clears at once and the op never completes
        begin
            int n_done;
            n_done = 0;
            @(negedge clk);
            op = 4'h4; a = 16'hFFFF; b = 16'h0001; cin = 1'b0; rcin = 1'b1; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(posedge clk);
            #3;
            rst_n = 1'b0;
            #1;
            check("abort flags", {busy, done, cout, rcout, ovf, zero}, 6'b0);
            check("abort result", result, 16'h0);
            check("abort alu bus", {alu_a, alu_b, alu_op, alu_cin, alu_rcin}, 14'h0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            for (int cyc = 0; cyc < 10; cyc++) begin
                @(posedge clk);
                #1;
                if (done) n_done++;
            end
            check("abort no done", n_done, 0);
            run_op(4'h4, 16'h1234, 16'h4321, 1'b1, 1'b0, "after_abort", cseq);
        end

        // Randomised ops against the whole-word reference
        for (int i = 0; i < 30; i++) begin
            run_op(ops[$urandom_range(0, 4)], 16'($urandom), 16'($urandom),
                   1'($urandom), 1'($urandom), "random", cseq);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu4_nibble_sequencer
`default_nettype wire

// File: doc/alu4_nibble_sequencer.md
# alu4_nibble_sequencer

Multi-cycle controller that runs the combinational 4-bit ALU core over operands of `NIBBLES` nibbles, one nibble per clock. It latches a wide request, presents one nibble pair per cycle to the ALU, and chains the math carry and rotate carry between nibbles. It also accumulates result and flags, then reports completion with a start/busy/done handshake. It sits between the register/control logic and the shared ALU core, which is the only arithmetic resource.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width in nibbles (W = 4·NIBBLES); legal range 2..8.

Ports:
- `clk`  in  1  clock; one clock domain, all state on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request strobe; accepted only when `busy`=0.
- `op`  in  4  ALU opcode; latched on accept.
- `a`, `b`  in  W  operands; latched on accept.
- `cin`  in  1  math carry-in for the first nibble.
- `rcin`  in  1  rotate carry-in for the first nibble.
- `busy`  out  1  high while nibbles are being processed.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  W  final result.
- `cout`, `rcout`, `ovf`, `zero`  out  1  final flags.
- `alu_a`, `alu_b`  out  4  nibble operands to the ALU core.
- `alu_op`  out  4  opcode to the ALU core.
- `alu_cin`, `alu_rcin`  out  1  carries to the ALU core.
- `alu_y`  in  4  ALU result nibble.
- `alu_cout`, `alu_rcout`, `alu_ovf`  in  1  ALU carry and overflow outputs.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE →RUN on `start`.
  - RUN →DONE after NIBBLES cycles.
  - DONE →RUN if `start`, else →IDLE.
- On accept:
  - latch `op`, `a`, `b`, `cin`, `rcin`;
  - clear the nibble counter;
  - set the zero accumulator to 1.
- Nibble order is set by `op_is_msb_first(op)`:
  - MSB-first for right shifts/rotates (op[3:2]=11 with op[0]=1, and op=0111);
  - LSB-first for all other ops.
- Each RUN cycle drives:
  - `alu_a`/`alu_b` from nibble k of the latched operands, where k = counter (LSB-first) or NIBBLES-1-counter (MSB-first);
  - `alu_op` from the latched op.
- Carry chaining:
  - first nibble: `alu_cin`=latched `cin`, `alu_rcin`=latched `rcin`;
  - later nibbles: previous cycle's `alu_cout`/`alu_rcout`.
- At each RUN edge:
  - `alu_y` is written into nibble k of the result register;
  - the zero accumulator is ANDed with (`alu_y`==0);
  - the carry registers are updated.
- Final flags:
  - `cout`/`rcout` come from the last processed nibble;
  - `ovf` is `alu_ovf` of the last nibble, and is meaningful only for LSB-first ops;
  - `zero` is the AND of all per-nibble zero terms.
- Arithmetic shift right across nibbles is not corrected. The ALU core replicates bit 3 of each nibble; the controller passes it through unchanged.
- Outside RUN, the `alu_*` outputs drive 0.

## Timing
- Cycle 0: `start`=1 with `busy`=0 is sampled.
- Cycles 1..NIBBLES: `busy`=1, one nibble per cycle.
- Cycle NIBBLES+1: `busy`=0, `done`=1.
- Latency from the accepting edge to `done` is NIBBLES+1 cycles. Throughput is one op per NIBBLES+1 cycles (back-to-back via the DONE→RUN transition).
- `result` and flags are valid from the `done` cycle and held until the next accept.
- `start` while `busy`=1 is ignored: not queued, no error.
- Reset (any time, including mid-RUN) has immediate effect:
  - state returns to IDLE;
  - `busy`, `done`, `result`, `cout`, `rcout`, `ovf`, `zero` all go to 0;
  - `alu_*` outputs go to 0;
  - no `done` is produced for the aborted op.
- The ALU core is combinational. The path `alu_*` out →`alu_y`/carries in must close within one cycle.

## Structure
- Shared package `alu4_pkg` holds:
  - opcode constants: `OP_ADC`=4'h4 (A+B+cin), `OP_RRC`=4'hF (rotate right through rcin), `OP_SHR`=4'hD;
  - function `op_is_msb_first`;
  - state enum `seq_state_t`.
- No sub-module. The ALU core stays outside and is connected at the parent level, so the bench can substitute a reference model.

## Test plan
- ADC, NIBBLES=4, a=16'hFFFF, b=16'h0001, cin=0 → `result`=16'h0000, `cout`=1, `zero`=1, `ovf`=0, `done` exactly 5 cycles after accept.
- ADC, a=16'h7FFF, b=16'h0001, cin=0 → `result`=16'h8000, `ovf`=1, `cout`=0, `zero`=0.
- RRC, a=16'h1234, rcin=1 → `result`=16'h891A, `rcout`=0. Monitor shows `alu_a` sequence 1,2,3,4 (MSB-first).
- `start` held high continuously → accepts only in IDLE/DONE cycles. `done` pulses every 5 cycles; no acceptance while `busy`.
- `rst_n` low during RUN cycle 2 → all outputs 0 immediately. No `done`. Next `start` after release completes normally.
- ADC, a=16'h00F0, b=16'h0010, cin=1 → `result`=16'h0101. Chained carry from nibble 1 into nibble 2 is checked per cycle on `alu_cin`.
